// File: rtl/ram_sync.sv
// Synchronous single-port RAM with a request/ready handshake, programmable wait
// states and an error pulse for illegal (rd+wr or out-of-range) requests.
module ram_sync #(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 15,
  parameter int DEPTH       = 32768,
  parameter int WAIT_STATES = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  input  logic                  rd,
  input  logic                  wr,
  output logic                  ready,
  output logic                  error
);

  localparam int CNT_W  = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic                    armed_q, armed_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic                    rd_q, rd_d;
  logic                    wr_q, wr_d;
  logic [DATA_WIDTH-1:0]   data_out_q, data_out_d;
  logic                    ready_q, ready_d;
  logic                    error_q, error_d;

  logic [DATA_WIDTH-1:0]   mem [0:DEPTH-1];
  logic [MEM_AW-1:0]       mem_idx_s;
  logic [DATA_WIDTH-1:0]   mem_rdata_s;
  logic                    mem_we_s;
  logic                    req_s;
  logic                    accept_s;
  logic                    illegal_s;

  assign req_s     = rd | wr;
  assign accept_s  = (state_q == IDLE) && req_s && armed_q;
  assign mem_idx_s = addr_q[MEM_AW-1:0];
  // Upper address bits only feed the range check; they never alias into storage.
  assign illegal_s = (rd_q && wr_q) || ({1'b0, addr_q} >= DEPTH_L);

  // Storage read port, only consumed for legal reads.
  always_comb begin
    mem_rdata_s = mem[mem_idx_s];
  end

  // Next-state, handshake and access-outcome logic.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    data_out_d = data_out_q;
    ready_d    = 1'b0;
    error_d    = 1'b0;
    mem_we_s   = 1'b0;

    // A request held past ready must not re-execute until rd/wr drop.
    if (accept_s) begin
      armed_d = 1'b0;
    end else if (!req_s) begin
      armed_d = 1'b1;
    end else begin
      armed_d = armed_q;
    end

    case (state_q)
      IDLE: begin
        if (accept_s) begin
          addr_d  = addr;
          wdata_d = data_in;
          rd_d    = rd;
          wr_d    = wr;
          cnt_d   = CNT_W'(WAIT_STATES);
          state_d = BUSY;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (cnt_q != {CNT_W{1'b0}}) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          ready_d = 1'b1;
          state_d = DONE;
          if (illegal_s) begin
            error_d = 1'b1;
          end else if (rd_q) begin
            data_out_d = mem_rdata_s;
          end else begin
            mem_we_s = 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control and output registers; reset wins over everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      armed_q    <= 1'b1;
      cnt_q      <= {CNT_W{1'b0}};
      addr_q     <= {ADDR_WIDTH{1'b0}};
      wdata_q    <= {DATA_WIDTH{1'b0}};
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      data_out_q <= {DATA_WIDTH{1'b0}};
      ready_q    <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      armed_q    <= armed_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      data_out_q <= data_out_d;
      ready_q    <= ready_d;
      error_q    <= error_d;
    end
  end

  // Storage write port; contents survive reset, but a reset edge blocks the write.
  always_ff @(posedge clk) begin
    if (mem_we_s && !reset) begin
      mem[mem_idx_s] <= wdata_q;
    end
  end

  assign data_out = data_out_q;
  assign ready    = ready_q;
  assign error    = error_q;

endmodule

// File: tb/tb_ram_sync.sv
// Directed bench: three ram_sync instances (2, 0 and 3 wait states) driven
// through a shared access task with hand-computed expectations.
module tb_ram_sync;

  logic        clk;
  logic        reset_a [3];
  logic        rd_a    [3];
  logic        wr_a    [3];
  logic [15:0] addr_a  [3];
  logic [7:0]  din_a   [3];
  logic [7:0]  dout_a  [3];
  logic        ready_a [3];
  logic        error_a [3];

  int total;
  int bad;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // inst 0: WAIT_STATES=2, DEPTH=1000, ADDR_WIDTH=10
  ram_sync #(.DATA_WIDTH(8), .ADDR_WIDTH(10), .DEPTH(1000), .WAIT_STATES(2)) u_ws2 (
    .clk(clk), .reset(reset_a[0]), .addr(addr_a[0][9:0]), .data_in(din_a[0]),
    .data_out(dout_a[0]), .rd(rd_a[0]), .wr(wr_a[0]), .ready(ready_a[0]), .error(error_a[0])
  );

  // inst 1: WAIT_STATES=0, DEPTH=256
  ram_sync #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .DEPTH(256), .WAIT_STATES(0)) u_ws0 (
    .clk(clk), .reset(reset_a[1]), .addr(addr_a[1][7:0]), .data_in(din_a[1]),
    .data_out(dout_a[1]), .rd(rd_a[1]), .wr(wr_a[1]), .ready(ready_a[1]), .error(error_a[1])
  );

  // inst 2: WAIT_STATES=3, DEPTH=64
  ram_sync #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .DEPTH(64), .WAIT_STATES(3)) u_ws3 (
    .clk(clk), .reset(reset_a[2]), .addr(addr_a[2][7:0]), .data_in(din_a[2]),
    .data_out(dout_a[2]), .rd(rd_a[2]), .wr(wr_a[2]), .ready(ready_a[2]), .error(error_a[2])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // One handshake on instance i. exp_lat counts falling edges from the drive
  // point to the first one where ready is seen (WAIT_STATES + 2).
  // chg scrambles addr/data_in once the access is in BUSY.
  task automatic access(input int i, input logic r, input logic w,
                        input logic [15:0] a, input logic [7:0] d,
                        input int exp_lat, input logic exp_err,
                        input logic chg, output logic [7:0] dout);
    int lat;
    rd_a[i]   = r;
    wr_a[i]   = w;
    addr_a[i] = a;
    din_a[i]  = d;
    lat = 0;
    dout = 8'h00;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (ready_a[i] === 1'b1) begin
        lat = k;
        break;
      end
      if (chg && k == 1) begin
        addr_a[i] = a + 16'd1;
        din_a[i]  = ~d;
      end
    end
    check($sformatf("lat_i%0d_a%0h", i, a), lat, exp_lat);
    check($sformatf("err_i%0d_a%0h", i, a), {31'd0, error_a[i]}, {31'd0, exp_err});
    dout = dout_a[i];
    rd_a[i] = 1'b0;
    wr_a[i] = 1'b0;
    @(negedge clk);
    check($sformatf("pulse_i%0d_a%0h", i, a), {30'd0, ready_a[i], error_a[i]}, 32'd0);
  endtask

  logic [7:0] q;
  int pulses;
  int first_at;
  logic seen_ready;

  initial begin
    total = 0;
    bad   = 0;
    for (int i = 0; i < 3; i++) begin
      reset_a[i] = 1'b1;
      rd_a[i]    = 1'b0;
      wr_a[i]    = 1'b0;
      addr_a[i]  = 16'h0000;
      din_a[i]   = 8'h00;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst_state_i%0d", i), {22'd0, dout_a[i], ready_a[i], error_a[i]}, 32'd0);
      reset_a[i] = 1'b0;
    end
    @(negedge clk);

    // Basic read/write, 2 wait states
    access(0, 1'b0, 1'b1, 16'h0010, 8'hA5, 4, 1'b0, 1'b0, q);
    check("wr_keeps_dout", {24'd0, q}, 32'h00);
    access(0, 1'b1, 1'b0, 16'h0010, 8'h00, 4, 1'b0, 1'b0, q);
    check("rd_10", {24'd0, q}, 32'hA5);

    // Out of range with DEPTH=1000
    access(0, 1'b0, 1'b1, 16'd1000, 8'h42, 4, 1'b1, 1'b0, q);
    check("oor_keeps_dout", {24'd0, q}, 32'hA5);
    access(0, 1'b1, 1'b0, 16'd1023, 8'h00, 4, 1'b1, 1'b0, q);
    check("oor_rd_keeps_dout", {24'd0, q}, 32'hA5);
    access(0, 1'b0, 1'b1, 16'd999, 8'h42, 4, 1'b0, 1'b0, q);
    access(0, 1'b1, 1'b0, 16'd999, 8'h00, 4, 1'b0, 1'b0, q);
    check("rd_999", {24'd0, q}, 32'h42);

    // Inputs changed during BUSY are ignored
    access(0, 1'b0, 1'b1, 16'h0005, 8'h00, 4, 1'b0, 1'b0, q);
    access(0, 1'b0, 1'b1, 16'h0004, 8'h3C, 4, 1'b0, 1'b1, q);
    access(0, 1'b1, 1'b0, 16'h0004, 8'h00, 4, 1'b0, 1'b0, q);
    check("rd_4_latched", {24'd0, q}, 32'h3C);
    access(0, 1'b1, 1'b0, 16'h0005, 8'h00, 4, 1'b0, 1'b0, q);
    check("rd_5_untouched", {24'd0, q}, 32'h00);

    // Zero wait states: held rd gives a single pulse, right after edge N+1
    access(1, 1'b0, 1'b1, 16'h0020, 8'h6E, 2, 1'b0, 1'b0, q);
    rd_a[1] = 1'b1;
    addr_a[1] = 16'h0020;
    pulses = 0;
    first_at = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (ready_a[1] === 1'b1) begin
        pulses++;
        if (first_at == 0) first_at = k;
      end
    end
    rd_a[1] = 1'b0;
    check("held_rd_pulses", pulses, 32'd1);
    check("held_rd_first", first_at, 32'd2);
    check("held_rd_data", {24'd0, dout_a[1]}, 32'h6E);
    @(negedge clk);

    // Simultaneous rd+wr is illegal and leaves storage intact
    access(1, 1'b0, 1'b1, 16'h0003, 8'h11, 2, 1'b0, 1'b0, q);
    access(1, 1'b1, 1'b1, 16'h0003, 8'hFF, 2, 1'b1, 1'b0, q);
    check("both_keeps_dout", {24'd0, q}, 32'h6E);
    access(1, 1'b1, 1'b0, 16'h0003, 8'h00, 2, 1'b0, 1'b0, q);
    check("rd_3_after_both", {24'd0, q}, 32'h11);

    // Reset in the second BUSY cycle of a 3-wait-state write
    access(2, 1'b0, 1'b1, 16'h0007, 8'h00, 5, 1'b0, 1'b0, q);
    access(2, 1'b0, 1'b1, 16'h0008, 8'h99, 5, 1'b0, 1'b0, q);
    access(2, 1'b1, 1'b0, 16'h0008, 8'h00, 5, 1'b0, 1'b0, q);
    check("rd_8", {24'd0, q}, 32'h99);
    wr_a[2] = 1'b1;
    addr_a[2] = 16'h0007;
    din_a[2] = 8'h5A;
    @(negedge clk);
    reset_a[2] = 1'b1;
    wr_a[2] = 1'b0;
    seen_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (ready_a[2] === 1'b1) seen_ready = 1'b1;
      if (k == 1) reset_a[2] = 1'b0;
    end
    check("rst_no_ready", {31'd0, seen_ready}, 32'd0);
    check("rst_dout", {23'd0, dout_a[2], error_a[2]}, 32'd0);
    access(2, 1'b1, 1'b0, 16'h0007, 8'h00, 5, 1'b0, 1'b0, q);
    check("rd_7_aborted", {24'd0, q}, 32'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ram_sync.md
Name: ram_sync

Overview:
- Parametrised synchronous single-port RAM for the CPU data/address bus.
- Replaces level-triggered, inout-driven memory access with a clocked request/ready handshake.
- Adds configurable data width, depth and wait states, plus error reporting for illegal requests.
- Sits between the CPU bus unit and storage; the bus unit holds `rd`/`wr` until `ready`.

Parameters:
- `DATA_WIDTH`, 8, word width in bits.
- `ADDR_WIDTH`, 15, address bus width.
- `DEPTH`, 32768, number of words implemented; must be ≤ 2^`ADDR_WIDTH`.
- `WAIT_STATES`, 1, extra cycles inserted before an access completes; 0 is legal.

Ports:
- `clk`  in  1  system clock, all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `addr`  in  `ADDR_WIDTH`  word address, sampled at request acceptance.
- `data_in`  in  `DATA_WIDTH`  write data, sampled at request acceptance.
- `data_out`  out  `DATA_WIDTH`  read data, registered.
- `rd`  in  1  read request, level, held until `ready`.
- `wr`  in  1  write request, level, held until `ready`.
- `ready`  out  1  one-cycle completion pulse.
- `error`  out  1  one-cycle pulse coincident with `ready` when the request was illegal.

Behaviour:
- Reset (sync, active-high) forces:
  - state = IDLE, `armed` = 1, counter = 0;
  - `data_out` = 0, `ready` = 0, `error` = 0.
  - Memory contents are not cleared.
- Reset has priority over every other event. Reset during BUSY aborts the access: no memory write, no `ready`.
- States: IDLE, BUSY, DONE.
- IDLE:
  - A request is accepted at edge N when (`rd` | `wr`) & `armed`.
  - On acceptance, latch `addr`, `data_in`, `rd`, `wr`; load counter = `WAIT_STATES`; go to BUSY.
  - `armed` is cleared on acceptance and set again at any edge where `rd` = 0 and `wr` = 0.
  - A request held high past `ready` is therefore never re-executed. The requester must drop `rd`/`wr` for at least one cycle between accesses.
- BUSY:
  - If counter ≠ 0: decrement the counter and stay in BUSY.
  - If counter = 0: perform the access, set `ready` = 1, go to DONE.
  - Inputs changing during BUSY are ignored; only the latched values are used.
- Access outcome:
  - Legal read: `data_out` ← mem[latched addr].
  - Legal write: mem[latched addr] ← latched data; `data_out` unchanged.
  - Illegal request: both `rd` and `wr` latched high, or latched addr ≥ `DEPTH`. Then `error` = 1 together with `ready`, no memory change, `data_out` unchanged.
- DONE: `ready` and `error` clear at the next edge; go to IDLE.
- Latency: `ready` is high during exactly one cycle, starting at edge N+1+`WAIT_STATES`.
  - Minimum request spacing: 3 cycles for `WAIT_STATES` = 0 (accept, done, idle/re-arm).
- `data_out` holds the last successful read value indefinitely.
- `addr` bits above clog2(`DEPTH`) participate only in the range check. There is no aliasing or wrap-around; out-of-range addresses error.
- `ready` and `error` never assert outside DONE. `error` never asserts without `ready`.

Test Plan:
- Basic read/write (`WAIT_STATES` = 2):
  - Stimulus: write 0xA5 to addr 0x0010, drop `wr`, read 0x0010.
  - Response: `ready` 3 cycles after each acceptance; `data_out` = 0xA5 after the read; `error` = 0.
- Zero-wait latency (`WAIT_STATES` = 0):
  - Stimulus: `rd` accepted at edge N.
  - Response: `ready` high only in the cycle after edge N+1.
  - Stimulus: `rd` held high for 10 cycles.
  - Response: exactly one `ready` pulse.
- Simultaneous request:
  - Stimulus: `rd` = `wr` = 1 with addr 0x0003 and `data_in` 0xFF, after a prior write of 0x11 there.
  - Response: `ready` = `error` = 1 for one cycle; a later read returns 0x11.
- Out of range (`DEPTH` = 1000, `ADDR_WIDTH` = 10):
  - Stimulus: write to addr 1000 → `error` pulse with `ready`.
  - Stimulus: write to addr 999 → no error; readback correct.
- Reset mid-access (`WAIT_STATES` = 3):
  - Stimulus: assert `reset` in the 2nd BUSY cycle of a write of 0x5A to addr 7, whose prior value is 0x00.
  - Response: no `ready`; `data_out` = 0; a later read of addr 7 returns 0x00.
- Inputs ignored mid-access:
  - Stimulus: change `addr`/`data_in` during BUSY of a write of 0x3C to addr 4.
  - Response: only addr 4 is updated to 0x3C.
